// File: rtl/interrupt_ack_sequencer_8259a.sv
// interrupt_ack_sequencer_8259a: INTA handshake sequencer for an 8259A-style PIC.
// Raises INT, freezes the acknowledged level, strobes the ISR, drives vector/CALL bytes, auto-EOI.
//
// Ports:
//   clock, reset_n        clock and asynchronous active-low reset
//   inta_n                CPU acknowledge strobe (already synchronous)
//   interrupt_to_service  one-hot resolved request, 0 = none
//   mode_8086, auto_eoi   ICW4 uPM / AEOI
//   vector_base           ICW2 T7..T3
//   call_base             {ICW2 A15..A8, ICW1 A7..A5}
//   interrupt_to_cpu      INT pin
//   latch_in_service      one-cycle ISR set strobe, with interrupt (one-hot level)
//   end_of_interrupt      one-cycle auto-EOI clear mask
//   data_out, data_out_enable  data bus byte and drive enable
//
// Build option: define MCS80_CALL_MODE_EN to support the 3-pulse MCS-80 CALL sequence;
// otherwise mode_8086/call_base are ignored and the 2-pulse 8086 sequence is always used.
module interrupt_ack_sequencer_8259a #(
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        inta_n,
    input  logic [7:0]  interrupt_to_service,
    input  logic        mode_8086,
    input  logic        auto_eoi,
    input  logic [4:0]  vector_base,
    input  logic [10:0] call_base,
    output logic        interrupt_to_cpu,
    output logic        latch_in_service,
    output logic [7:0]  interrupt,
    output logic [7:0]  end_of_interrupt,
    output logic [7:0]  data_out,
    output logic        data_out_enable
);

    typedef enum logic [2:0] {
        IDLE,
        P1,
        G1,
        P2,
        G2,
        P3
    } state_t;

    state_t     state;
    state_t     state_d;
    logic       inta_q;
    logic [2:0] acked_level;
    logic [2:0] level_d;
    logic       spurious;
    logic       spur_d;

    logic       int_d;
    logic       latch_d;
    logic [7:0] intr_d;
    logic [7:0] eoi_d;
    logic [7:0] dout_d;
    logic       den_d;

    logic       fall;
    logic       rise;
    logic       mcs;
    logic [7:0] call_lo;
    logic [7:0] call_hi;
    logic [7:0] p2_byte;
    logic [7:0] eoi_mask;
    logic [2:0] req_level;
    logic       has_req;

    assign fall = inta_q & ~inta_n;
    assign rise = ~inta_q & inta_n;
    assign has_req = |interrupt_to_service;

`ifdef MCS80_CALL_MODE_EN
    assign mcs     = ~mode_8086;
    assign call_lo = {call_base[2:0], acked_level, 2'b00};
    assign call_hi = call_base[10:3];
`else
    logic unused_cfg;
    assign unused_cfg = ^{mode_8086, call_base};
    assign mcs        = 1'b0;
    assign call_lo    = 8'h00;
    assign call_hi    = 8'h00;
`endif

    assign p2_byte  = mcs ? call_lo : {vector_base, acked_level};
    // A spurious acknowledge never set an ISR bit, so it must not clear one.
    assign eoi_mask = (auto_eoi && !spurious) ? (8'd1 << acked_level) : 8'd0;

    always_comb begin
        req_level = 3'd0;
        unique case (1'b1)
            interrupt_to_service[0]: req_level = 3'd0;
            interrupt_to_service[1]: req_level = 3'd1;
            interrupt_to_service[2]: req_level = 3'd2;
            interrupt_to_service[3]: req_level = 3'd3;
            interrupt_to_service[4]: req_level = 3'd4;
            interrupt_to_service[5]: req_level = 3'd5;
            interrupt_to_service[6]: req_level = 3'd6;
            interrupt_to_service[7]: req_level = 3'd7;
            default:                 req_level = 3'd0;
        endcase
    end

    // Outputs are computed for the state being entered and registered,
    // so each effect appears the cycle after the strobe edge is seen.
    always_comb begin
        state_d = state;
        level_d = acked_level;
        spur_d  = spurious;
        int_d   = 1'b0;
        latch_d = 1'b0;
        intr_d  = 8'h00;
        eoi_d   = 8'h00;
        dout_d  = 8'h00;
        den_d   = 1'b0;
        unique case (state)
            IDLE: begin
                int_d = has_req & ~fall;
                if (fall) begin
                    state_d = P1;
                    if (has_req) begin
                        level_d = req_level;
                        spur_d  = 1'b0;
                        latch_d = 1'b1;
                        intr_d  = interrupt_to_service;
                    end else begin
                        level_d = SPURIOUS_LEVEL;
                        spur_d  = 1'b1;
                    end
                    if (mcs) begin
                        dout_d = 8'hCD;
                        den_d  = 1'b1;
                    end
                end
            end
            P1: begin
                if (rise) begin
                    state_d = G1;
                end else if (mcs) begin
                    dout_d = 8'hCD;
                    den_d  = 1'b1;
                end
            end
            G1: begin
                if (fall) begin
                    state_d = P2;
                    dout_d  = p2_byte;
                    den_d   = 1'b1;
                end
            end
            P2: begin
                if (rise) begin
                    if (mcs) begin
                        state_d = G2;
                    end else begin
                        state_d = IDLE;
                        eoi_d   = eoi_mask;
                    end
                end else begin
                    dout_d = p2_byte;
                    den_d  = 1'b1;
                end
            end
            G2: begin
                if (fall) begin
                    state_d = P3;
                    dout_d  = call_hi;
                    den_d   = 1'b1;
                end
            end
            P3: begin
                if (rise) begin
                    state_d = IDLE;
                    eoi_d   = eoi_mask;
                end else begin
                    dout_d = call_hi;
                    den_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            inta_q           <= 1'b1;
            acked_level      <= 3'd0;
            spurious         <= 1'b0;
            interrupt_to_cpu <= 1'b0;
            latch_in_service <= 1'b0;
            interrupt        <= 8'h00;
            end_of_interrupt <= 8'h00;
            data_out         <= 8'h00;
            data_out_enable  <= 1'b0;
        end else begin
            state            <= state_d;
            inta_q           <= inta_n;
            acked_level      <= level_d;
            spurious         <= spur_d;
            interrupt_to_cpu <= int_d;
            latch_in_service <= latch_d;
            interrupt        <= intr_d;
            end_of_interrupt <= eoi_d;
            data_out         <= dout_d;
            data_out_enable  <= den_d;
        end
    end

endmodule

// File: tb/tb_interrupt_ack_sequencer_8259a.sv
// tb_interrupt_ack_sequencer_8259a: directed and random INTA sequences
// checked against a byte-list model of the acknowledge protocol.
module tb_interrupt_ack_sequencer_8259a;

`ifdef MCS80_CALL_MODE_EN
    localparam bit MCS_BUILD = 1'b1;
`else
    localparam bit MCS_BUILD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        inta_n;
    logic [7:0]  interrupt_to_service;
    logic        mode_8086;
    logic        auto_eoi;
    logic [4:0]  vector_base;
    logic [10:0] call_base;
    logic        interrupt_to_cpu;
    logic        latch_in_service;
    logic [7:0]  interrupt;
    logic [7:0]  end_of_interrupt;
    logic [7:0]  data_out;
    logic        data_out_enable;

    int checks = 0;
    int errors = 0;

    interrupt_ack_sequencer_8259a dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .inta_n               (inta_n),
        .interrupt_to_service (interrupt_to_service),
        .mode_8086            (mode_8086),
        .auto_eoi             (auto_eoi),
        .vector_base          (vector_base),
        .call_base            (call_base),
        .interrupt_to_cpu     (interrupt_to_cpu),
        .latch_in_service     (latch_in_service),
        .interrupt            (interrupt),
        .end_of_interrupt     (end_of_interrupt),
        .data_out             (data_out),
        .data_out_enable      (data_out_enable)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " int"}, {7'd0, interrupt_to_cpu}, 8'h00);
        chk({tag, " latch"}, {7'd0, latch_in_service}, 8'h00);
        chk({tag, " interrupt"}, interrupt, 8'h00);
        chk({tag, " eoi"}, end_of_interrupt, 8'h00);
        chk({tag, " dout"}, data_out, 8'h00);
        chk({tag, " den"}, {7'd0, data_out_enable}, 8'h00);
    endtask

    // Reference: the acknowledge is a list of bus bytes, one per INTA pulse.
    task automatic run_seq(input string tag, input logic [7:0] its,
                           input logic [7:0] its_late, input logic m86,
                           input logic aeoi, input logic [4:0] vb,
                           input logic [10:0] cb);
        logic       mcs;
        logic       spur;
        logic [2:0] lvl;
        int         npulse;
        logic [7:0] bytes[3];
        logic       en[3];
        logic [7:0] eoi_exp;
        mcs  = MCS_BUILD && !m86;
        spur = (its == 8'h00);
        lvl  = 3'd7;
        for (int i = 0; i < 8; i++)
            if (its[i]) lvl = 3'(i);
        if (mcs) begin
            npulse   = 3;
            bytes[0] = 8'hCD;
            en[0]    = 1'b1;
            bytes[1] = {cb[2:0], lvl, 2'b00};
            en[1]    = 1'b1;
            bytes[2] = cb[10:3];
            en[2]    = 1'b1;
        end else begin
            npulse   = 2;
            bytes[0] = 8'h00;
            en[0]    = 1'b0;
            bytes[1] = {vb, lvl};
            en[1]    = 1'b1;
            bytes[2] = 8'h00;
            en[2]    = 1'b0;
        end
        eoi_exp = (aeoi && !spur) ? (8'd1 << lvl) : 8'd0;

        interrupt_to_service = its;
        mode_8086   = m86;
        auto_eoi    = aeoi;
        vector_base = vb;
        call_base   = cb;
        tick();
        tick();
        chk({tag, " int_pre"}, {7'd0, interrupt_to_cpu}, {7'd0, !spur});

        for (int p = 0; p < npulse; p++) begin
            inta_n = 1'b0;
            tick();
            if (p == 0) begin
                chk({tag, " int_ack"}, {7'd0, interrupt_to_cpu}, 8'h00);
                chk({tag, " latch"}, {7'd0, latch_in_service}, {7'd0, !spur});
                chk({tag, " interrupt"}, interrupt, spur ? 8'h00 : its);
                interrupt_to_service = its_late;
            end
            chk({tag, " den_low"}, {7'd0, data_out_enable}, {7'd0, en[p]});
            chk({tag, " dout_low"}, data_out, bytes[p]);
            tick();
            chk({tag, " latch_once"}, {7'd0, latch_in_service}, 8'h00);
            chk({tag, " dout_hold"}, data_out, bytes[p]);
            repeat ($urandom_range(0, 2)) tick();
            inta_n = 1'b1;
            tick();
            chk({tag, " den_rise"}, {7'd0, data_out_enable}, 8'h00);
            chk({tag, " dout_rise"}, data_out, 8'h00);
            chk({tag, " eoi"}, end_of_interrupt,
                (p == npulse - 1) ? eoi_exp : 8'h00);
            tick();
            chk({tag, " eoi_once"}, end_of_interrupt, 8'h00);
            if (p != npulse - 1)
                chk({tag, " int_mid"}, {7'd0, interrupt_to_cpu}, 8'h00);
        end
        chk({tag, " int_post"}, {7'd0, interrupt_to_cpu},
            {7'd0, its_late != 8'h00});
        interrupt_to_service = 8'h00;
        tick();
        tick();
    endtask

    initial begin
        logic [7:0]  r_its;
        logic [7:0]  r_late;
        int          r;

        reset_n              = 1'b0;
        inta_n               = 1'b1;
        interrupt_to_service = 8'h00;
        mode_8086            = 1'b1;
        auto_eoi             = 1'b0;
        vector_base          = 5'h00;
        call_base            = 11'h000;
        #2;
        chk_all_zero("reset");
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk_all_zero("idle");

        run_seq("t1_8086", 8'h08, 8'h00, 1'b1, 1'b0, 5'h11, 11'h000);
        run_seq("t2_aeoi", 8'h20, 8'h00, 1'b1, 1'b1, 5'h03, 11'h000);
        run_seq("t3_spur", 8'h00, 8'h00, 1'b1, 1'b1, 5'h02, 11'h000);
        if (MCS_BUILD)
            run_seq("t4_mcs80", 8'h04, 8'h00, 1'b0, 1'b0, 5'h00, 11'h7FD);

        interrupt_to_service = 8'h04;
        mode_8086            = 1'b1;
        vector_base          = 5'h09;
        tick();
        inta_n = 1'b0;
        tick();
        inta_n = 1'b1;
        tick();
        inta_n = 1'b0;
        tick();
        chk("t5 den_p2", {7'd0, data_out_enable}, 8'h01);
        #3;
        reset_n = 1'b0;
        #1;
        chk_all_zero("t5_async");
        inta_n = 1'b1;
        interrupt_to_service = 8'h00;
        tick();
        tick();
        chk_all_zero("t5_held");
        #2;
        reset_n = 1'b1;
        run_seq("t5_after", 8'h04, 8'h00, 1'b1, 1'b1, 5'h09, 11'h000);

        run_seq("t6_change", 8'h01, 8'h80, 1'b1, 1'b0, 5'h15, 11'h000);

        for (int n = 0; n < 24; n++) begin
            r      = int'($urandom_range(0, 8));
            r_its  = (r == 8) ? 8'h00 : (8'd1 << r);
            r      = int'($urandom_range(0, 8));
            r_late = (r == 8) ? 8'h00 : (8'd1 << r);
            run_seq("rand", r_its, r_late, 1'($urandom), 1'($urandom),
                    5'($urandom), 11'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
